// File: rtl/petra_rx_if.sv
// Bundle of receive-link signals between the transceiver/decoder/arbiter side and petra_rx.
// Purely wiring: no storage and no added latency.
// Flow control is pulse/level based (frame_valid, ecc_done, ack_req/ack_grant/ack_done).
interface petra_rx_if #(
  parameter int MESSAGE_SIZE = 8
);
  localparam int PACKET_SIZE = MESSAGE_SIZE + 3;

  // Transceiver / decoder side
  logic                    frame_valid;
  logic                    ecc_done;
  logic [PACKET_SIZE-1:0]  packet_in;
  logic                    ecc_ok;

  // Message delivery
  logic [MESSAGE_SIZE-1:0] data_out;
  logic                    irq_rx;

  // (N)ACK transmit request towards the arbiter
  logic                    ack_req;
  logic [1:0]              ack_kind;
  logic                    ack_seq;
  logic                    ack_grant;
  logic                    ack_done;

  // Indications to the TX state machine and status
  logic [1:0]              notify_ack;
  logic                    notify_seq;
  logic                    expected_seq;
  logic [7:0]              err_count;
  logic [7:0]              dup_count;

  // Controller side
  modport master (
    input  frame_valid, ecc_done, packet_in, ecc_ok, ack_grant, ack_done,
    output data_out, irq_rx, ack_req, ack_kind, ack_seq,
           notify_ack, notify_seq, expected_seq, err_count, dup_count
  );

  // Environment side (transceiver, decoder, arbiter, TX FSM)
  modport slave (
    output frame_valid, ecc_done, packet_in, ecc_ok, ack_grant, ack_done,
    input  data_out, irq_rx, ack_req, ack_kind, ack_seq,
           notify_ack, notify_seq, expected_seq, err_count, dup_count
  );
endinterface

// File: rtl/petra_rx.sv
// Receive-side stop-and-wait link controller: decode handshake, classify, deliver, (N)ACK request.
// Latency: ecc_done to irq_rx is 2 cycles; notify_ack follows ecc_done by 2 cycles.
// Backpressure: frames arriving while busy are dropped; ack_req is held until grant and done/timeout.
module petra_rx #(
  parameter int MESSAGE_SIZE   = 8,
  parameter int PACKET_SIZE    = MESSAGE_SIZE + 3,
  parameter int DECODE_TIMEOUT = 15,
  parameter int ACK_TIMEOUT    = 1023
) (
  input logic        clock,
  input logic        reset,
  petra_rx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    CLASSIFY,
    DELIVER,
    ACK_REQ,
    ACK_WAIT
  } state_t;

  localparam logic [1:0] TYPE_NORMAL = 2'b00;
  localparam logic [1:0] TYPE_ACK    = 2'b01;
  localparam logic [1:0] TYPE_NACK   = 2'b10;
  localparam logic [1:0] TYPE_EXT    = 2'b11;

  localparam logic [1:0]  KIND_ACK  = 2'b01;
  localparam logic [1:0]  KIND_NACK = 2'b10;

  localparam logic [15:0] DEC_LIMIT = 16'(DECODE_TIMEOUT);
  localparam logic [15:0] ACK_LIMIT = 16'(ACK_TIMEOUT);

  state_t                  state_q, state_d;
  logic [15:0]             timer_q, timer_d;
  logic [PACKET_SIZE-1:0]  pkt_q, pkt_d;
  logic                    ok_q, ok_d;
  logic [MESSAGE_SIZE-1:0] data_out_q, data_out_d;
  logic                    irq_rx_q, irq_rx_d;
  logic [1:0]              ack_kind_q, ack_kind_d;
  logic                    ack_seq_q, ack_seq_d;
  logic [1:0]              notify_ack_q, notify_ack_d;
  logic                    notify_seq_q, notify_seq_d;
  logic                    expected_seq_q, expected_seq_d;
  logic [7:0]              err_count_q, err_count_d;
  logic [7:0]              dup_count_q, dup_count_d;
  logic                    err_inc, dup_inc;

  // Field views of the latched packet: {seq, type, payload}
  logic                    pkt_seq;
  logic [1:0]              pkt_type;
  logic [MESSAGE_SIZE-1:0] pkt_payload;

  assign pkt_seq     = pkt_q[PACKET_SIZE-1];
  assign pkt_type    = pkt_q[PACKET_SIZE-2 -: 2];
  assign pkt_payload = pkt_q[MESSAGE_SIZE-1:0];

  // Next-state, datapath and counter update logic
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    pkt_d          = pkt_q;
    ok_d           = ok_q;
    data_out_d     = data_out_q;
    irq_rx_d       = 1'b0;
    ack_kind_d     = ack_kind_q;
    ack_seq_d      = ack_seq_q;
    notify_ack_d   = 2'b00;
    notify_seq_d   = notify_seq_q;
    expected_seq_d = expected_seq_q;
    err_inc        = 1'b0;
    dup_inc        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.frame_valid) begin
          state_d = DECODE;
          timer_d = '0;
        end
      end

      DECODE: begin
        // A result arriving in the timeout cycle is still accepted
        if (bus.ecc_done) begin
          pkt_d   = bus.packet_in;
          ok_d    = bus.ecc_ok;
          state_d = CLASSIFY;
        end else if (timer_q + 16'd1 == DEC_LIMIT) begin
          err_inc    = 1'b1;
          ack_kind_d = KIND_NACK;
          ack_seq_d  = expected_seq_q;
          state_d    = ACK_REQ;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      CLASSIFY: begin
        if (!ok_q) begin
          err_inc    = 1'b1;
          ack_kind_d = KIND_NACK;
          ack_seq_d  = expected_seq_q;
          state_d    = ACK_REQ;
        end else begin
          case (pkt_type)
            TYPE_ACK, TYPE_NACK: begin
              // Peer's (N)ACK goes to the TX side; we never answer it
              notify_ack_d = pkt_type;
              notify_seq_d = pkt_seq;
              state_d      = IDLE;
            end
            TYPE_EXT: begin
              err_inc    = 1'b1;
              ack_kind_d = KIND_NACK;
              ack_seq_d  = expected_seq_q;
              state_d    = ACK_REQ;
            end
            TYPE_NORMAL: begin
              if (pkt_seq == expected_seq_q) begin
                // Payload and irq are registered so they appear together in DELIVER
                data_out_d = pkt_payload;
                irq_rx_d   = 1'b1;
                state_d    = DELIVER;
              end else begin
                // Duplicate: our earlier ACK was lost, so re-acknowledge it
                dup_inc    = 1'b1;
                ack_kind_d = KIND_ACK;
                ack_seq_d  = pkt_seq;
                state_d    = ACK_REQ;
              end
            end
          endcase
        end
      end

      DELIVER: begin
        expected_seq_d = ~expected_seq_q;
        ack_kind_d     = KIND_ACK;
        ack_seq_d      = pkt_seq;
        state_d        = ACK_REQ;
      end

      ACK_REQ: begin
        if (bus.ack_grant) begin
          timer_d = '0;
          state_d = ACK_WAIT;
        end
      end

      ACK_WAIT: begin
        // Completion in the timeout cycle counts as success
        if (bus.ack_done) begin
          state_d = IDLE;
        end else if (timer_q + 16'd1 == ACK_LIMIT) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    err_count_d = (err_inc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    dup_count_d = (dup_inc && dup_count_q != 8'hFF) ? dup_count_q + 8'd1 : dup_count_q;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      pkt_q          <= '0;
      ok_q           <= 1'b0;
      data_out_q     <= '0;
      irq_rx_q       <= 1'b0;
      ack_kind_q     <= 2'b00;
      ack_seq_q      <= 1'b0;
      notify_ack_q   <= 2'b00;
      notify_seq_q   <= 1'b0;
      expected_seq_q <= 1'b0;
      err_count_q    <= '0;
      dup_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      pkt_q          <= pkt_d;
      ok_q           <= ok_d;
      data_out_q     <= data_out_d;
      irq_rx_q       <= irq_rx_d;
      ack_kind_q     <= ack_kind_d;
      ack_seq_q      <= ack_seq_d;
      notify_ack_q   <= notify_ack_d;
      notify_seq_q   <= notify_seq_d;
      expected_seq_q <= expected_seq_d;
      err_count_q    <= err_count_d;
      dup_count_q    <= dup_count_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.irq_rx       = irq_rx_q;
  assign bus.ack_req      = (state_q == ACK_REQ) || (state_q == ACK_WAIT);
  assign bus.ack_kind     = ack_kind_q;
  assign bus.ack_seq      = ack_seq_q;
  assign bus.notify_ack   = notify_ack_q;
  assign bus.notify_seq   = notify_seq_q;
  assign bus.expected_seq = expected_seq_q;
  assign bus.err_count    = err_count_q;
  assign bus.dup_count    = dup_count_q;

endmodule

// File: tb/tb_petra_rx.sv
// Bench for petra_rx: packet table plus timeout, reset and saturation sequences.
// Output events (irq_rx, ack_req rise, notify_ack) are matched against a scoreboard queue.
// Environment grants and completes every (N)ACK request unless a sequence says otherwise.
module tb_petra_rx;
  localparam int MS = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  petra_rx_if #(.MESSAGE_SIZE(MS)) bus ();

  petra_rx #(.MESSAGE_SIZE(MS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard event: kind 0 = irq_rx (a=data), 1 = ack_req rise (a=kind,b=seq), 2 = notify (a=code,b=seq)
  typedef struct {
    int         kind;
    logic [7:0] a;
    logic       b;
  } ev_t;
  ev_t sb[$];

  typedef struct {
    logic       s;
    logic [1:0] t;
    logic [7:0] p;
    logic       ok;
    logic       exp_irq;
    logic [1:0] exp_ack;
    logic       exp_aseq;
    logic [1:0] exp_ntf;
    logic       exp_nseq;
    logic [7:0] exp_err;
    logic [7:0] exp_dup;
    logic       exp_eseq;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic take(int kind, logic [7:0] a, logic b);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d actual=%0h required=none", kind, a);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_val", 32'(a), 32'(e.a));
      chk("event_seq", 32'(b), 32'(e.b));
    end
  endtask

  // Output monitor, sampled on the falling edge
  logic ack_prev = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.irq_rx === 1'b1) take(0, bus.data_out, 1'b0);
      if (bus.ack_req === 1'b1 && ack_prev !== 1'b1) take(1, 8'(bus.ack_kind), bus.ack_seq);
      if (bus.notify_ack !== 2'b00) take(2, 8'(bus.notify_ack), bus.notify_seq);
    end
    ack_prev = bus.ack_req;
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(int kind, logic [7:0] a, logic b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endtask

  task automatic send(logic s, logic [1:0] t, logic [7:0] p, logic ok);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick(2);
    bus.packet_in = {s, t, p};
    bus.ecc_ok    = ok;
    bus.ecc_done  = 1'b1;
    tick();
    bus.ecc_done  = 1'b0;
    bus.packet_in = '0;
  endtask

  task automatic wait_ack_req(string name);
    int n = 0;
    while (bus.ack_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.ack_req), 32'd1);
  endtask

  task automatic service_ack();
    wait_ack_req("ack_req_seen");
    bus.ack_grant = 1'b1;
    tick();
    bus.ack_grant = 1'b0;
    bus.ack_done  = 1'b1;
    tick();
    bus.ack_done  = 1'b0;
    tick();
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_data_out"}, 32'(bus.data_out), 32'd0);
    chk({tag, "_irq_rx"}, 32'(bus.irq_rx), 32'd0);
    chk({tag, "_ack_req"}, 32'(bus.ack_req), 32'd0);
    chk({tag, "_ack_kind"}, 32'(bus.ack_kind), 32'd0);
    chk({tag, "_ack_seq"}, 32'(bus.ack_seq), 32'd0);
    chk({tag, "_notify_ack"}, 32'(bus.notify_ack), 32'd0);
    chk({tag, "_notify_seq"}, 32'(bus.notify_seq), 32'd0);
    chk({tag, "_expected_seq"}, 32'(bus.expected_seq), 32'd0);
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'd0);
    chk({tag, "_dup_count"}, 32'(bus.dup_count), 32'd0);
  endtask

  initial begin
    bus.frame_valid = 1'b0;
    bus.ecc_done    = 1'b0;
    bus.packet_in   = '0;
    bus.ecc_ok      = 1'b0;
    bus.ack_grant   = 1'b0;
    bus.ack_done    = 1'b0;

    //          s     t      p      ok    irq   ack    aseq  ntf    nseq  err    dup    eseq  data
    vecs[0] = '{1'b0, 2'b00, 8'hA5, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 1'b1, 8'hA5};
    vecs[1] = '{1'b0, 2'b00, 8'hA5, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 8'd0, 8'd1, 1'b1, 8'hA5};
    vecs[2] = '{1'b1, 2'b00, 8'h3C, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 8'd1, 8'd1, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 8'd1, 8'd1, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 2'b10, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0, 8'd1, 8'd1, 1'b1, 8'hA5};
    vecs[5] = '{1'b0, 2'b11, 8'h55, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 8'd2, 8'd1, 1'b1, 8'hA5};
    vecs[6] = '{1'b1, 2'b00, 8'h3C, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 8'd2, 8'd1, 1'b0, 8'h3C};
    vecs[7] = '{1'b0, 2'b00, 8'h7E, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 8'd2, 8'd1, 1'b1, 8'h7E};

    // Reset state
    tick(2);
    chk_reset_outputs("rst0");
    reset = 1'b0;
    tick();

    // Packet table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_irq) push(0, vecs[i].p, 1'b0);
      if (vecs[i].exp_ntf != 2'b00) push(2, 8'(vecs[i].exp_ntf), vecs[i].exp_nseq);
      if (vecs[i].exp_ack != 2'b00) push(1, 8'(vecs[i].exp_ack), vecs[i].exp_aseq);
      send(vecs[i].s, vecs[i].t, vecs[i].p, vecs[i].ok);
      if (vecs[i].exp_ack != 2'b00) begin
        service_ack();
      end else begin
        tick(3);
      end
      chk($sformatf("v%0d_ack_req_idle", i), 32'(bus.ack_req), 32'd0);
      chk($sformatf("v%0d_err_count", i), 32'(bus.err_count), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_dup_count", i), 32'(bus.dup_count), 32'(vecs[i].exp_dup));
      chk($sformatf("v%0d_expected_seq", i), 32'(bus.expected_seq), 32'(vecs[i].exp_eseq));
      chk($sformatf("v%0d_data_out", i), 32'(bus.data_out), 32'(vecs[i].exp_data));
    end

    // Decode timeout: 15 cycles in DECODE without ecc_done
    push(1, 8'h02, 1'b1);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick(14);
    chk("dec_to_before", 32'(bus.ack_req), 32'd0);
    tick();
    chk("dec_to_after", 32'(bus.ack_req), 32'd1);
    service_ack();
    chk("dec_to_err", 32'(bus.err_count), 32'd3);

    // ecc_done in the timeout cycle is accepted
    push(0, 8'h99, 1'b0);
    push(1, 8'h01, 1'b1);
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick(14);
    bus.packet_in = {1'b1, 2'b00, 8'h99};
    bus.ecc_ok    = 1'b1;
    bus.ecc_done  = 1'b1;
    tick();
    bus.ecc_done  = 1'b0;
    service_ack();
    chk("dec_edge_err", 32'(bus.err_count), 32'd3);
    chk("dec_edge_data", 32'(bus.data_out), 32'h99);
    chk("dec_edge_eseq", 32'(bus.expected_seq), 32'd0);

    // ACK timeout after grant; a frame_valid while waiting is ignored
    push(1, 8'h01, 1'b1);
    send(1'b1, 2'b00, 8'h44, 1'b1);
    wait_ack_req("ack_to_req");
    bus.ack_grant = 1'b1;
    tick();
    bus.ack_grant = 1'b0;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    tick(1021);
    chk("ack_to_before", 32'(bus.ack_req), 32'd1);
    tick();
    chk("ack_to_after", 32'(bus.ack_req), 32'd0);
    tick(25);
    chk("ack_to_err", 32'(bus.err_count), 32'd4);
    chk("ack_to_dup", 32'(bus.dup_count), 32'd2);
    chk("ack_to_idle", 32'(bus.ack_req), 32'd0);

    // Reset while in ACK_WAIT
    push(0, 8'h11, 1'b0);
    push(1, 8'h01, 1'b0);
    send(1'b0, 2'b00, 8'h11, 1'b1);
    wait_ack_req("rst_wait_req");
    bus.ack_grant = 1'b1;
    tick();
    bus.ack_grant = 1'b0;
    reset = 1'b1;
    tick();
    chk_reset_outputs("rst1");
    reset = 1'b0;
    tick();

    // err_count saturation
    for (int i = 0; i < 254; i++) begin
      push(1, 8'h02, 1'b0);
      send(1'b0, 2'b11, 8'h00, 1'b1);
      service_ack();
    end
    chk("sat_254", 32'(bus.err_count), 32'd254);
    push(1, 8'h02, 1'b0);
    send(1'b0, 2'b11, 8'h00, 1'b1);
    service_ack();
    chk("sat_255", 32'(bus.err_count), 32'd255);
    push(1, 8'h02, 1'b0);
    send(1'b0, 2'b11, 8'h00, 1'b1);
    service_ack();
    chk("sat_hold", 32'(bus.err_count), 32'd255);

    tick(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/petra_rx.md
Name: petra_rx

Overview:
- Receive-side link controller for the stop-and-wait light link.
- Takes raw frame arrivals from the transceiver and drives the ECC decode handshake.
- Classifies decoded packets as NORMAL, ACK, NACK or EXTENDED, delivers in-sequence messages, and requests ACK/NACK transmissions through the arbiter's priority input.
- Forwards received ACK/NACK indications to the TX state machine.

Parameters:
- MESSAGE_SIZE, 8, payload width in bits.
- PACKET_SIZE, MESSAGE_SIZE+3, packet layout {seq[1], type[2], payload[MESSAGE_SIZE]}; seq is the MSB.
- DECODE_TIMEOUT, 15, maximum cycles to wait for ecc_done.
- ACK_TIMEOUT, 1023, maximum cycles to wait for ack_done after a grant.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- frame_valid  in  1  one-cycle pulse: transceiver received a complete frame.
- ecc_done  in  1  one-cycle pulse: decoder result valid this cycle.
- packet_in  in  PACKET_SIZE  decoded packet; sampled only when ecc_done=1.
- ecc_ok  in  1  decoder reports a correct or corrected packet; sampled with ecc_done.
- data_out  out  MESSAGE_SIZE  last delivered payload.
- irq_rx  out  1  one-cycle pulse: new message on data_out.
- ack_req  out  1  priority request to the arbiter (level).
- ack_kind  out  2  01 = ACK, 10 = NACK; stable while ack_req=1.
- ack_seq  out  1  sequence bit carried by the outgoing (N)ACK.
- ack_grant  in  1  arbiter grant for the priority request.
- ack_done  in  1  one-cycle pulse: transceiver finished sending the (N)ACK.
- notify_ack  out  2  one-cycle pulse code to TX FSM: 01 = ACK received, 10 = NACK received, 00 otherwise.
- notify_seq  out  1  sequence bit of the received (N)ACK, valid with notify_ack.
- expected_seq  out  1  sequence bit of the next acceptable NORMAL packet.
- err_count  out  8  count of decode failures, timeouts and illegal types; saturates at 255.
- dup_count  out  8  count of duplicate NORMAL packets; saturates at 255.

Behaviour:
- Reset values: data_out=0, irq_rx=0, ack_req=0, ack_kind=00, ack_seq=0, notify_ack=00, notify_seq=0, expected_seq=0, err_count=0, dup_count=0, state=IDLE, timers=0.
- Reset mid-operation aborts any decode or ACK in progress and drops ack_req on the next edge.
- irq_rx and notify_ack are high for exactly one cycle and are 0 in every other cycle.
- IDLE:
  - frame_valid -> DECODE, timer cleared.
  - frame_valid in any other state is ignored; no counter changes.
- DECODE:
  - ecc_done -> latch packet_in and ecc_ok, go to CLASSIFY.
  - If ecc_done and the timer reaching DECODE_TIMEOUT coincide, ecc_done wins.
  - Timer reaches DECODE_TIMEOUT without ecc_done -> err_count+1, NACK with ack_seq=expected_seq, go to ACK_REQ.
- CLASSIFY (one cycle):
  - ecc_ok=0 -> err_count+1, NACK with ack_seq=expected_seq -> ACK_REQ.
  - type ACK or NACK -> notify_ack=type and notify_seq=seq next cycle -> IDLE. No reply is sent.
  - type EXTENDED -> err_count+1, NACK with ack_seq=expected_seq -> ACK_REQ.
  - type NORMAL, seq==expected_seq -> DELIVER.
  - type NORMAL, seq!=expected_seq (duplicate) -> dup_count+1, ACK with ack_seq=seq, no delivery -> ACK_REQ.
- DELIVER (one cycle):
  - data_out<=payload, irq_rx=1, expected_seq toggles.
  - Set ACK with ack_seq=received seq -> ACK_REQ.
  - Latency from ecc_done to irq_rx is 2 cycles.
- ACK_REQ:
  - ack_req=1; ack_kind and ack_seq are held.
  - ack_grant -> ACK_WAIT, timer cleared.
- ACK_WAIT:
  - ack_req stays 1.
  - ack_done -> ack_req=0 -> IDLE.
  - Timer reaches ACK_TIMEOUT -> ack_req=0, err_count+1 -> IDLE.
  - If ack_done and the timeout coincide, ack_done wins and err_count is not incremented.
- Counters saturate at 255 and never wrap. Timers are 16-bit.
- The sequence bit wraps naturally: 0 -> 1 -> 0.

Test Plan:
- Reset, then NORMAL packet seq=0, payload 0xA5, ecc_ok=1 -> irq_rx pulse 2 cycles after ecc_done, data_out=0xA5, expected_seq=1, ack_req rises with ack_kind=01, ack_seq=0; ack_grant then ack_done -> ack_req=0, state IDLE.
- Same seq=0 packet resent after the step above -> no irq_rx, data_out still 0xA5, dup_count=1, ACK sent with ack_seq=0.
- Packet with ecc_ok=0 while expected_seq=1 -> err_count+1, NACK with ack_kind=10, ack_seq=1, no irq_rx.
- Received ACK packet seq=1 -> notify_ack=01, notify_seq=1 for one cycle, ack_req stays 0; received NACK packet -> notify_ack=10.
- frame_valid with no ecc_done for 15 cycles -> NACK requested, err_count+1; separately, grant with no ack_done for 1023 cycles -> ack_req drops, err_count+1.
- Reset asserted in ACK_WAIT -> all outputs return to reset values next cycle; err_count held at 255 plus one more error -> stays 255.
